// File: rtl/mult_unit_pkg.sv
// Shared definitions for the sequential HI/LO multiplier: state encoding and
// default operand width / terminal iteration count.
package mult_unit_pkg;

  localparam int MU_WIDTH = 32;
  localparam int MU_LAST  = MU_WIDTH - 1;

  typedef enum logic [1:0] {
    MU_IDLE = 2'd0,
    MU_RUN  = 2'd1,
    MU_DONE = 2'd2
  } mu_state_e;

endpackage

// File: rtl/mult_unit_adder32.sv
// Ripple-carry adder used for the partial-product add and for the
// two's-complement negations (operand magnitude and product sign fix-up).
module adder32
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = MU_WIDTH
) (
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin
);

  logic [WIDTH:0] carry_s;

  // Bit-serial carry chain, LSB first.
  always_comb begin
    S          = {WIDTH{1'b0}};
    carry_s    = {(WIDTH + 1){1'b0}};
    carry_s[0] = Cin;
    for (int i = 0; i < WIDTH; i++) begin
      S[i]         = A[i] ^ B[i] ^ carry_s[i];
      carry_s[i+1] = (A[i] & B[i]) | (A[i] & carry_s[i]) | (B[i] & carry_s[i]);
    end
  end

  assign Cout = carry_s[WIDTH];

endmodule

// File: rtl/mult_unit.sv
// Sequential shift-add multiplier for mult/multu. Works on operand magnitudes,
// resolves one multiplier bit per cycle and fixes the sign of the 2*WIDTH-bit
// product while writing HI/LO.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = MU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  mu_state_e        state_r, state_s;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] mplier_r, mcand_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_r, busy_r, done_r;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic             take_start_s;
  logic             neg_a_s, neg_b_s;
  logic [WIDTH-1:0] a_neg_s, b_neg_s, mag_a_s, mag_b_s;
  logic             a_cout_unused_s, b_cout_unused_s, hi_cout_unused_s;
  logic [WIDTH-1:0] pp_sum_s;
  logic             pp_cout_s;
  logic [WIDTH:0]   acc_t_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] lo_neg_s, hi_neg_s;
  logic             lo_cout_s;

  // A new request is accepted in IDLE and, back-to-back, in DONE; never in RUN.
  assign take_start_s = start & ((state_r == MU_IDLE) | (state_r == MU_DONE));

  // Operand magnitudes: negate only for signed ops with the sign bit set.
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign neg_a_s = signed_op & A[WIDTH-1];
  assign neg_b_s = signed_op & B[WIDTH-1];

  adder32 #(.WIDTH(WIDTH)) u_mag_a (
    .S(a_neg_s), .Cout(a_cout_unused_s), .A(~A), .B({WIDTH{1'b0}}), .Cin(1'b1)
  );
  adder32 #(.WIDTH(WIDTH)) u_mag_b (
    .S(b_neg_s), .Cout(b_cout_unused_s), .A(~B), .B({WIDTH{1'b0}}), .Cin(1'b1)
  );

  assign mag_a_s = neg_a_s ? a_neg_s : A;
  assign mag_b_s = neg_b_s ? b_neg_s : B;

  // Partial-product add; the carry lands in acc bit WIDTH before the shift.
  adder32 #(.WIDTH(WIDTH)) u_pp_add (
    .S(pp_sum_s), .Cout(pp_cout_s), .A(acc_r[WIDTH-1:0]), .B(mcand_r), .Cin(1'b0)
  );

  assign acc_t_s = mplier_r[0] ? {pp_cout_s, pp_sum_s} : acc_r;

  // Product sign fix-up: LO negates with carry-in 1, HI chains LO's carry.
  assign prod_s = {acc_r[WIDTH-1:0], mplier_r};

  adder32 #(.WIDTH(WIDTH)) u_neg_lo (
    .S(lo_neg_s), .Cout(lo_cout_s), .A(~prod_s[WIDTH-1:0]), .B({WIDTH{1'b0}}), .Cin(1'b1)
  );
  adder32 #(.WIDTH(WIDTH)) u_neg_hi (
    .S(hi_neg_s), .Cout(hi_cout_unused_s), .A(~prod_s[2*WIDTH-1:WIDTH]), .B({WIDTH{1'b0}}),
    .Cin(lo_cout_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= MU_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      MU_IDLE: begin
        if (start) state_s = MU_RUN;
        else       state_s = MU_IDLE;
      end
      MU_RUN: begin
        if (cnt_r == LAST) state_s = MU_DONE;
        else               state_s = MU_RUN;
      end
      MU_DONE: begin
        if (start) state_s = MU_RUN;
        else       state_s = MU_IDLE;
      end
      default: state_s = MU_IDLE;
    endcase
  end

  // Datapath: operand latch on accept, one shift-add step per RUN cycle,
  // HI/LO written only when leaving DONE so partial products never show.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r    <= {(WIDTH + 1){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      neg_r    <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      if (take_start_s) begin
        mcand_r  <= mag_a_s;
        mplier_r <= mag_b_s;
        neg_r    <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
        acc_r    <= {(WIDTH + 1){1'b0}};
        cnt_r    <= {CW{1'b0}};
      end else if (state_r == MU_RUN) begin
        acc_r    <= {1'b0, acc_t_s[WIDTH:1]};
        mplier_r <= {acc_t_s[0], mplier_r[WIDTH-1:1]};
        cnt_r    <= cnt_r + CW'(1);
      end
      if (state_r == MU_DONE) begin
        hi_r <= neg_r ? hi_neg_s : prod_s[2*WIDTH-1:WIDTH];
        lo_r <= neg_r ? lo_neg_s : prod_s[WIDTH-1:0];
      end
    end
  end

  // Registered status flags derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != MU_IDLE);
      done_r <= (state_s == MU_DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: expected products are pushed to a
// scoreboard queue at issue time and popped when HI/LO become valid.
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  mult_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .A(A), .B(B), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    if (s) begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
    end else begin
      ea = {32'h0, a};
      eb = {32'h0, b};
    end
    return ea * eb;
  endfunction

  function automatic logic [63:0] pop_exp();
    if (exp_q.size() == 0) return 64'hDEAD_BEEF_DEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  // Drive one start pulse (sampled at the edge between the two negedges).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] expv);
    @(negedge clk);
    A = a; B = b; signed_op = s; start = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; n = negedges waited (-1 on timeout).
  task automatic wait_done(output int n, output int busy_low);
    n = 0;
    busy_low = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; A = 32'h0; B = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, HI, LO} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_hold: busy=%b done=%b HI=%h LO=%h, want 0 0 0 0", busy, done, HI, LO);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, HI, LO} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_idle: busy=%b done=%b HI=%h LO=%h, want 0 0 0 0", busy, done, HI, LO);
    end
  endtask

  // Table-driven ops with literal expected products (unsigned then signed).
  task automatic test_table();
    logic [31:0] ta [12] = '{32'd3, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] tb_ [12] = '{32'd5, 32'hFFFF_FFFF, 32'h1234_5678, 32'd2, 32'h0001_0000, 32'd2,
                              32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF7, 32'd1, 32'd0};
    logic        ts [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [63:0] te [12] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFE_0000_0001, 64'h0,
                             64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0001_FFFF_FFFE,
                             64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000,
                             64'hFFFF_FFFF_FFFF_FFC1, 64'hFFFF_FFFF_8000_0000, 64'h0};
    int n, bl;
    logic [63:0] e;
    for (int i = 0; i < 12; i++) begin
      issue(ta[i], tb_[i], ts[i], te[i]);
      wait_done(n, bl);
      checks++;
      if (n !== 32) begin
        failures++;
        $display("FAIL latency[%0d]: done after %0d cycles, want 32", i, n);
      end
      checks++;
      if (bl !== 0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_run[%0d]: busy low %0d cycles, busy=%b in done cycle, want 0 and 1", i, bl, busy);
      end
      @(negedge clk);
      e = pop_exp();
      checks++;
      if ({HI, LO} !== e) begin
        failures++;
        $display("FAIL product[%0d]: HI:LO=%h:%h, want %h:%h", i, HI, LO, e[63:32], e[31:0]);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL post_done[%0d]: busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
  endtask

  // Random operands checked against a 64-bit sign-extended product model.
  task automatic test_random();
    int n, bl;
    logic [31:0] a, b;
    logic s;
    logic [63:0] e;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      issue(a, b, s, model(a, b, s));
      wait_done(n, bl);
      @(negedge clk);
      e = pop_exp();
      checks++;
      if (n !== 32 || {HI, LO} !== e) begin
        failures++;
        $display("FAIL random[%0d] %h*%h s=%b: lat=%0d HI:LO=%h:%h, want 32 %h:%h",
                 i, a, b, s, n, HI, LO, e[63:32], e[31:0]);
      end
    end
  endtask

  // A start pulse during RUN must be ignored.
  task automatic test_ignore_start();
    int n, bl, extra;
    logic [63:0] e;
    issue(32'd6, 32'd7, 1'b0, 64'h0000_0000_0000_002A);
    repeat (3) @(negedge clk);
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; signed_op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bl);
    checks++;
    if (n !== 28) begin
      failures++;
      $display("FAIL ignore_latency: done after %0d more cycles, want 28", n);
    end
    @(negedge clk);
    e = pop_exp();
    checks++;
    if ({HI, LO} !== e) begin
      failures++;
      $display("FAIL ignore_result: HI:LO=%h:%h, want %h:%h", HI, LO, e[63:32], e[31:0]);
    end
    extra = 0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL ignore_no_second: %0d busy/done cycles, want 0", extra);
    end
  endtask

  // Second start in the DONE cycle chains straight into RUN.
  task automatic test_back_to_back();
    int n, bl;
    logic [63:0] e;
    issue(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    wait_done(n, bl);
    A = 32'hFFFF_FFFE; B = 32'd3; signed_op = 1'b1; start = 1'b1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk);
    start = 1'b0;
    e = pop_exp();
    checks++;
    if ({HI, LO} !== e || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: HI:LO=%h:%h busy=%b, want %h:%h busy=1", HI, LO, busy, e[63:32], e[31:0]);
    end
    wait_done(n, bl);
    checks++;
    if (n !== 32 || bl !== 0) begin
      failures++;
      $display("FAIL b2b_latency: done after %0d cycles, busy low %0d, want 32 0", n, bl);
    end
    @(negedge clk);
    e = pop_exp();
    checks++;
    if ({HI, LO} !== e) begin
      failures++;
      $display("FAIL b2b_second: HI:LO=%h:%h, want %h:%h", HI, LO, e[63:32], e[31:0]);
    end
  endtask

  // Reset mid-run clears HI/LO and suppresses done; reset beats start.
  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    A = 32'h1234_5678; B = 32'd9; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, HI, LO} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b HI=%h LO=%h, want 0 0 0 0", busy, done, HI, LO);
    end
    dones = 0;
    repeat (40) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_no_done: %0d done pulses, want 0", dones);
    end
    A = 32'd2; B = 32'd2; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_table();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_empty: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
